trd_ctrl: RTL and testbench

- Thread-lifecycle controller on the receiving end of the write-back stage's thread-control outputs (kill, sleep, wake, init_wb).
- Holds per-thread state and supplies the write-back stage with new_trd, the next free thread ID.
- Drives round-robin thread selection to fetch and issues per-thread flush requests.
- All state changes commit from the write-back stage, so they are precise.

---
 rtl/trd_pkg.sv | 20 ++
 rtl/trd_ctrl_rr_arb.sv | 28 ++
 rtl/trd_ctrl.sv | 127 ++++++++++++
 tb/tb_trd_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trd_pkg.sv
// Shared thread-control types and encodings for the thread-lifecycle controller,
// the instruction decoder and the write-back stage.
package trd_pkg;

  localparam int NUM_TRD = 8;
  localparam int TRD_W   = $clog2(NUM_TRD);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    RUN   = 2'd1,
    SLEEP = 2'd2
  } trd_state_t;

  // Thread-control opcodes as carried down the pipe to write-back
  localparam logic [2:0] TRD_CTRL_SLEEP = 3'b001;
  localparam logic [2:0] TRD_CTRL_WAKE  = 3'b010;
  localparam logic [2:0] TRD_CTRL_KILL  = 3'b011;
  localparam logic [2:0] TRD_CTRL_INIT  = 3'b111;

endpackage

// File: rtl/trd_ctrl_rr_arb.sv
// Rotate-priority arbiter: grants the first requester strictly after ptr,
// wrapping round so that ptr itself is granted last.
module rr_arb #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt,
  output logic         gnt_vld
);

  logic [W-1:0] idx;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    gnt_vld = |req;
    // Scan farthest-first so the nearest requester after ptr overwrites the rest;
    // the W-bit add wraps naturally because N is a power of two.
    for (int i = N; i >= 1; i--) begin
      idx = ptr + W'(i);
      if (req[idx]) gnt = idx;
    end
  end

endmodule

// File: rtl/trd_ctrl.sv
// Thread-lifecycle controller driven by write-back kill/sleep/wake/init events.
// Optional build macro TRD_PERF_EN adds saturating launch/kill counters.
module trd_ctrl #(
  parameter int NUM_TRD = trd_pkg::NUM_TRD,
  parameter int TRD_W   = $clog2(NUM_TRD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flushWB,
  input  logic               kill,
  input  logic               sleep,
  input  logic               wake,
  input  logic               init_wb,
  input  logic [TRD_W-1:0]   trd_id_wb,
  input  logic [TRD_W-1:0]   wake_trd,
  input  logic               fetch_stall,
  output logic [TRD_W-1:0]   new_trd,
  output logic               new_trd_vld,
  output logic [TRD_W-1:0]   fetch_trd,
  output logic               fetch_vld,
  output logic               flush_trd_vld,
  output logic [TRD_W-1:0]   flush_trd,
  output logic               init_load,
  output logic [TRD_W-1:0]   init_id,
  output logic               init_fail,
  output logic [NUM_TRD-1:0] trd_run,
`ifdef TRD_PERF_EN
  output logic [15:0]        perf_launch,
  output logic [15:0]        perf_kill,
`endif
  output logic               all_done
);

  import trd_pkg::*;

  trd_state_t         trd_st [NUM_TRD];
  logic [TRD_W-1:0]   rr_ptr;
  logic [NUM_TRD-1:0] free_mask;
  logic [NUM_TRD-1:0] run_mask;
  logic               ev_kill, ev_sleep, ev_wake, ev_init;

  always_comb begin
    free_mask = '0;
    run_mask  = '0;
    new_trd   = '0;
    for (int i = 0; i < NUM_TRD; i++) begin
      free_mask[i] = (trd_st[i] == FREE);
      run_mask[i]  = (trd_st[i] == RUN);
    end
    // Derived from registered state only, so WB sees a stable ID all cycle
    for (int i = NUM_TRD - 1; i >= 0; i--) begin
      if (free_mask[i]) new_trd = TRD_W'(i);
    end
  end

  assign new_trd_vld = |free_mask;
  assign trd_run     = run_mask;
  assign all_done    = &free_mask;

  rr_arb #(.N(NUM_TRD), .W(TRD_W)) u_rr_arb (
    .req     (run_mask),
    .ptr     (rr_ptr),
    .gnt     (fetch_trd),
    .gnt_vld (fetch_vld)
  );

  // Squashed WB instructions are ignored; overlapping requests resolve kill > sleep > wake > init
  assign ev_kill  = !flushWB && kill;
  assign ev_sleep = !flushWB && !kill && sleep;
  assign ev_wake  = !flushWB && !kill && !sleep && wake;
  assign ev_init  = !flushWB && !kill && !sleep && !wake && init_wb;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the state array is small and its reset value is architectural, so it is reset.
      for (int i = 0; i < NUM_TRD; i++) trd_st[i] <= (i == 0) ? RUN : FREE;
      rr_ptr        <= '0;
      flush_trd_vld <= 1'b0;
      flush_trd     <= '0;
      init_load     <= 1'b0;
      init_id       <= '0;
      init_fail     <= 1'b0;
    end else begin
      flush_trd_vld <= 1'b0;
      init_load     <= 1'b0;
      init_fail     <= 1'b0;

      if (ev_kill) begin
        trd_st[trd_id_wb] <= FREE;
        flush_trd_vld     <= 1'b1;
        flush_trd         <= trd_id_wb;
      end else if (ev_sleep) begin
        if (trd_st[trd_id_wb] == RUN) begin
          trd_st[trd_id_wb] <= SLEEP;
          flush_trd_vld     <= 1'b1;
          flush_trd         <= trd_id_wb;
        end
      end else if (ev_wake) begin
        if (wake_trd != trd_id_wb && trd_st[wake_trd] == SLEEP) trd_st[wake_trd] <= RUN;
      end else if (ev_init) begin
        if (new_trd_vld) begin
          trd_st[new_trd] <= RUN;
          init_load       <= 1'b1;
          init_id         <= new_trd;
        end else begin
          init_fail <= 1'b1;
        end
      end

      if (!fetch_stall && fetch_vld) rr_ptr <= fetch_trd;
    end
  end

`ifdef TRD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_launch <= '0;
      perf_kill   <= '0;
    end else begin
      if (ev_init && new_trd_vld && perf_launch != 16'hFFFF) perf_launch <= perf_launch + 16'd1;
      if (ev_kill && perf_kill != 16'hFFFF) perf_kill <= perf_kill + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trd_ctrl.sv
// Self-checking bench for trd_ctrl: directed scenarios plus randomized events
// compared against a thread-set reference model.
module tb_trd_ctrl;

  localparam int N = 8;
  localparam int W = 3;
  localparam int M_FREE = 0, M_RUN = 1, M_SLEEP = 2;

  logic         clk = 1'b0;
  logic         rst_n, flushWB, kill, sleep, wake, init_wb, fetch_stall;
  logic [W-1:0] trd_id_wb, wake_trd;
  logic [W-1:0] new_trd, fetch_trd, flush_trd, init_id;
  logic         new_trd_vld, fetch_vld, flush_trd_vld, init_load, init_fail, all_done;
  logic [N-1:0] trd_run;
`ifdef TRD_PERF_EN
  logic [15:0]  perf_launch, perf_kill;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model
  int m_st [N];
  int m_ptr;
  int m_flush_vld, m_flush_trd, m_init_load, m_init_id, m_init_fail;
  int m_launches, m_kills;

  always #5 clk = ~clk;

  trd_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flushWB       (flushWB),
    .kill          (kill),
    .sleep         (sleep),
    .wake          (wake),
    .init_wb       (init_wb),
    .trd_id_wb     (trd_id_wb),
    .wake_trd      (wake_trd),
    .fetch_stall   (fetch_stall),
    .new_trd       (new_trd),
    .new_trd_vld   (new_trd_vld),
    .fetch_trd     (fetch_trd),
    .fetch_vld     (fetch_vld),
    .flush_trd_vld (flush_trd_vld),
    .flush_trd     (flush_trd),
    .init_load     (init_load),
    .init_id       (init_id),
    .init_fail     (init_fail),
    .trd_run       (trd_run),
`ifdef TRD_PERF_EN
    .perf_launch   (perf_launch),
    .perf_kill     (perf_kill),
`endif
    .all_done      (all_done)
  );

  function automatic int m_run_mask();
    int m = 0;
    for (int i = 0; i < N; i++) if (m_st[i] == M_RUN) m += (1 << i);
    return m;
  endfunction

  function automatic int m_free_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_st[i] == M_FREE) c++;
    return c;
  endfunction

  function automatic int m_new();
    for (int i = 0; i < N; i++) if (m_st[i] == M_FREE) return i;
    return 0;
  endfunction

  function automatic int m_fetch();
    for (int k = 1; k <= N; k++) if (m_st[(m_ptr + k) % N] == M_RUN) return (m_ptr + k) % N;
    return 0;
  endfunction

  task automatic idle();
    flushWB = 0; kill = 0; sleep = 0; wake = 0; init_wb = 0;
    trd_id_wb = 0; wake_trd = 0; fetch_stall = 0;
  endtask

  // Advance one clock: model consumes the current inputs, DUT sampled #1 after the edge.
  task automatic tick();
    int nt, ft, id, wt;
    bit nv, fv;
    nt = m_new(); nv = (m_free_cnt() != 0);
    ft = m_fetch(); fv = (m_run_mask() != 0);
    id = int'(trd_id_wb); wt = int'(wake_trd);
    m_flush_vld = 0; m_init_load = 0; m_init_fail = 0;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_st[i] = (i == 0) ? M_RUN : M_FREE;
      m_ptr = 0; m_flush_trd = 0; m_init_id = 0; m_launches = 0; m_kills = 0;
    end else begin
      if (!flushWB) begin
        if (kill) begin
          m_st[id] = M_FREE; m_flush_vld = 1; m_flush_trd = id;
          if (m_kills < 65535) m_kills++;
        end else if (sleep) begin
          if (m_st[id] == M_RUN) begin m_st[id] = M_SLEEP; m_flush_vld = 1; m_flush_trd = id; end
        end else if (wake) begin
          if (wt != id && m_st[wt] == M_SLEEP) m_st[wt] = M_RUN;
        end else if (init_wb) begin
          if (nv) begin
            m_st[nt] = M_RUN; m_init_load = 1; m_init_id = nt;
            if (m_launches < 65535) m_launches++;
          end else m_init_fail = 1;
        end
      end
      if (!fetch_stall && fv) m_ptr = ft;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    tick(); tick();
    if (trd_run !== 8'h01) begin errors++; $display("FAIL reset_run got=%h exp=01", trd_run); end
    if (flush_trd_vld !== 0 || init_load !== 0 || init_fail !== 0) begin
      errors++; $display("FAIL reset_pulses got=%b%b%b exp=000", flush_trd_vld, init_load, init_fail);
    end
    if (all_done !== 0) begin errors++; $display("FAIL reset_all_done got=%b exp=0", all_done); end
    checks += 3;
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      if (fetch_trd !== 0 || fetch_vld !== 1) begin
        errors++; $display("FAIL reset_fetch got=%0d/%b exp=0/1", fetch_trd, fetch_vld);
      end
      if (new_trd !== 1 || new_trd_vld !== 1) begin
        errors++; $display("FAIL reset_new got=%0d/%b exp=1/1", new_trd, new_trd_vld);
      end
      checks += 2;
      tick();
    end
  endtask

  task automatic test_init();
    logic [W-1:0] prev;
    idle(); init_wb = 1; trd_id_wb = 0;
    tick(); idle();
    if (init_load !== 1 || init_id !== 1) begin
      errors++; $display("FAIL init_pulse got=%b/%0d exp=1/1", init_load, init_id);
    end
    if (trd_run !== 8'h03 || new_trd !== 2) begin
      errors++; $display("FAIL init_state got=%h/%0d exp=03/2", trd_run, new_trd);
    end
    checks += 2;
    prev = fetch_trd;
    tick();
    if (init_load !== 0) begin errors++; $display("FAIL init_one_cycle got=%b exp=0", init_load); end
    checks++;
    for (int c = 0; c < 4; c++) begin
      if (fetch_trd === prev || fetch_trd > 1) begin
        errors++; $display("FAIL init_alternate got=%0d prev=%0d", fetch_trd, prev);
      end
      checks++;
      prev = fetch_trd;
      tick();
    end
  endtask

  task automatic test_sleep_wake();
    idle(); sleep = 1; trd_id_wb = 1;
    tick(); idle();
    if (flush_trd_vld !== 1 || flush_trd !== 1 || trd_run !== 8'h01) begin
      errors++; $display("FAIL sleep got=%b/%0d/%h exp=1/1/01", flush_trd_vld, flush_trd, trd_run);
    end
    checks++;
    for (int c = 0; c < 2; c++) begin
      wake = 1; wake_trd = 1; trd_id_wb = 0;
      tick(); idle();
      if (trd_run !== 8'h03 || flush_trd_vld !== 0) begin
        errors++; $display("FAIL wake%0d got=%h/%b exp=03/0", c, trd_run, flush_trd_vld);
      end
      checks++;
    end
  endtask

  task automatic test_flush_gating();
    idle(); kill = 1; flushWB = 1; trd_id_wb = 0;
    tick(); idle();
    if (trd_run !== 8'h03 || flush_trd_vld !== 0) begin
      errors++; $display("FAIL flush_gate got=%h/%b exp=03/0", trd_run, flush_trd_vld);
    end
    checks++;
  endtask

  task automatic test_full();
    for (int c = 0; c < 6; c++) begin
      idle(); init_wb = 1;
      tick();
    end
    idle();
    if (trd_run !== 8'hFF || new_trd_vld !== 0) begin
      errors++; $display("FAIL full got=%h/%b exp=ff/0", trd_run, new_trd_vld);
    end
    checks++;
    init_wb = 1;
    tick(); idle();
    if (init_fail !== 1 || init_load !== 0 || trd_run !== 8'hFF) begin
      errors++; $display("FAIL init_fail got=%b/%b/%h exp=1/0/ff", init_fail, init_load, trd_run);
    end
    checks++;
    tick();
    if (init_fail !== 0) begin errors++; $display("FAIL init_fail_pulse got=%b exp=0", init_fail); end
    checks++;
  endtask

  task automatic test_kill_all();
    for (int t = 0; t < N; t++) begin
      if (all_done !== 0) begin errors++; $display("FAIL early_done at=%0d got=%b", t, all_done); end
      checks++;
      idle(); kill = 1; trd_id_wb = W'(t);
      tick(); idle();
      if (flush_trd_vld !== 1 || flush_trd !== W'(t)) begin
        errors++; $display("FAIL kill_flush got=%b/%0d exp=1/%0d", flush_trd_vld, flush_trd, t);
      end
      checks++;
    end
    if (all_done !== 1 || fetch_vld !== 0 || new_trd !== 0 || new_trd_vld !== 1) begin
      errors++; $display("FAIL kill_all got=%b/%b/%0d/%b exp=1/0/0/1", all_done, fetch_vld, new_trd, new_trd_vld);
    end
    checks++;
`ifdef TRD_PERF_EN
    if (perf_kill !== 16'(N) || perf_launch !== 16'd7) begin
      errors++; $display("FAIL perf got=%0d/%0d exp=%0d/7", perf_kill, perf_launch, N);
    end
    checks++;
`endif
  endtask

  task automatic test_random();
    int r, run_ids[$];
    idle(); rst_n = 0;
    tick(); rst_n = 1;
    for (int c = 0; c < 600; c++) begin
      idle();
      rst_n = ($urandom_range(0, 99) != 0);
      r = $urandom_range(0, 99);
      if (r < 6) kill = 1;
      else if (r < 20) sleep = 1;
      else if (r < 45) wake = 1;
      else if (r < 70) init_wb = 1;
      if ($urandom_range(0, 9) == 0) begin
        kill = 1'($urandom); sleep = 1'($urandom); wake = 1'($urandom); init_wb = 1'($urandom);
      end
      flushWB = ($urandom_range(0, 9) == 0);
      fetch_stall = ($urandom_range(0, 3) == 0);
      wake_trd = W'($urandom);
      run_ids.delete();
      for (int i = 0; i < N; i++) if (m_st[i] == M_RUN) run_ids.push_back(i);
      if (run_ids.size() != 0 && $urandom_range(0, 3) != 0)
        trd_id_wb = W'(run_ids[$urandom_range(0, run_ids.size() - 1)]);
      else
        trd_id_wb = W'($urandom);
      tick();
      if (trd_run !== N'(m_run_mask())) begin
        errors++; $display("FAIL rnd_run c=%0d got=%h exp=%h", c, trd_run, N'(m_run_mask()));
      end
      if (new_trd_vld !== (m_free_cnt() != 0) || (new_trd_vld && new_trd !== W'(m_new()))) begin
        errors++; $display("FAIL rnd_new c=%0d got=%0d/%b exp=%0d", c, new_trd, new_trd_vld, m_new());
      end
      if (fetch_vld !== (m_run_mask() != 0) || (fetch_vld && fetch_trd !== W'(m_fetch()))) begin
        errors++; $display("FAIL rnd_fetch c=%0d got=%0d/%b exp=%0d", c, fetch_trd, fetch_vld, m_fetch());
      end
      if (flush_trd_vld !== 1'(m_flush_vld) || (m_flush_vld == 1 && flush_trd !== W'(m_flush_trd))) begin
        errors++; $display("FAIL rnd_flush c=%0d got=%b/%0d exp=%0d/%0d", c, flush_trd_vld, flush_trd, m_flush_vld, m_flush_trd);
      end
      if (init_load !== 1'(m_init_load) || init_fail !== 1'(m_init_fail) ||
          (m_init_load == 1 && init_id !== W'(m_init_id))) begin
        errors++; $display("FAIL rnd_init c=%0d got=%b/%b/%0d exp=%0d/%0d/%0d", c, init_load, init_fail, init_id, m_init_load, m_init_fail, m_init_id);
      end
      if (all_done !== (m_free_cnt() == N)) begin
        errors++; $display("FAIL rnd_done c=%0d got=%b", c, all_done);
      end
      checks += 6;
`ifdef TRD_PERF_EN
      if (perf_launch !== 16'(m_launches) || perf_kill !== 16'(m_kills)) begin
        errors++; $display("FAIL rnd_perf c=%0d got=%0d/%0d exp=%0d/%0d", c, perf_launch, perf_kill, m_launches, m_kills);
      end
      checks++;
`endif
    end
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_init();
    test_sleep_wake();
    test_flush_gating();
    test_full();
    test_kill_all();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
